sdes_round_sequencer: RTL and testbench

Multi-round controller for the 8-bit Feistel cipher datapath. It accepts one 8-bit block plus a 12-bit master key over a valid/ready handshake. It iterates the 4-bit round function NROUNDS times, one round per clock, deriving a 6-bit round key each round. It returns the result over a valid/ready handshake. Encrypt and decrypt share the same hardware; decrypt only reverses the key order.

---
 rtl/sdes_pkg.sv | 16 +
 rtl/sdes_round_sequencer_if.sv | 14 +
 rtl/sdes_round_f.sv | 13 +
 rtl/sdes_round_sequencer.sv | 65 ++++++
 tb/tb_sdes_round_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdes_pkg.sv
// sdes_pkg: shared types, S-box, bit-index tables and round-key helper for the Feistel sequencer
package sdes_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] S1 [64] = '{
    4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8, 4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7,
    4'h0, 4'hF, 4'h7, 4'h4, 4'hE, 4'h2, 4'hD, 4'h1, 4'hA, 4'h6, 4'hC, 4'hB, 4'h9, 4'h5, 4'h3, 4'h8,
    4'h4, 4'h1, 4'hE, 4'h8, 4'hD, 4'h6, 4'h2, 4'hB, 4'hF, 4'hC, 4'h9, 4'h7, 4'h3, 4'hA, 4'h5, 4'h0,
    4'hF, 4'hC, 4'h8, 4'h2, 4'h4, 4'h9, 4'h1, 4'h7, 4'h5, 4'hB, 4'h3, 4'hE, 4'hA, 4'h0, 4'h6, 4'hD
  };
  // source bit of R (or s) for each output bit, listed MSB first
  localparam int E_IDX [6] = '{3, 2, 2, 1, 1, 0};
  localparam int P_IDX [4] = '{2, 1, 3, 0};
  function automatic logic [5:0] round_key(input logic [11:0] k, input int i);
    return 6'({k, k} >> (18 - i));
  endfunction
endpackage

// File: rtl/sdes_round_sequencer_if.sv
// sdes_round_sequencer_if: request/result handshake bundle between requester and sequencer
interface sdes_round_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic mode;
  logic [7:0] msg;
  logic [11:0] key;
  logic out_valid;
  logic out_ready;
  logic [7:0] cipher;
  logic busy;
  modport master (output in_valid, mode, msg, key, out_ready, input in_ready, out_valid, cipher, busy);
  modport slave (input in_valid, mode, msg, key, out_ready, output in_ready, out_valid, cipher, busy);
endinterface

// File: rtl/sdes_round_f.sv
// sdes_round_f: combinational Feistel round function F(K,R)
module sdes_round_f import sdes_pkg::*; (
  input  logic [5:0] k,
  input  logic [3:0] r,
  output logic [3:0] f
);
  logic [5:0] e, x;
  logic [3:0] s;
  for (genvar j = 0; j < 6; j++) assign e[5-j] = r[E_IDX[j]];
  assign x = e ^ k;
  assign s = S1[{x[5], x[0], x[4:1]}];
  for (genvar j = 0; j < 4; j++) assign f[3-j] = s[P_IDX[j]];
endmodule

// File: rtl/sdes_round_sequencer.sv
// sdes_round_sequencer: one-round-per-clock Feistel encrypt/decrypt controller
module sdes_round_sequencer import sdes_pkg::*; #(
  parameter int NROUNDS = 4,
  parameter int CTR_W   = 4
) (
  input logic clk,
  input logic rst,
  sdes_round_sequencer_if.slave bus
);
  localparam logic [CTR_W-1:0] LAST = CTR_W'(NROUNDS - 1);
  state_t state;
  logic [3:0] l, r, f;
  logic [11:0] key_q;
  logic mode_q;
  logic [CTR_W-1:0] ctr, idx;
  logic [5:0] k;
  assign idx = mode_q ? LAST - ctr : ctr;
  assign k = round_key(key_q, int'(idx));
  sdes_round_f u_f (.k(k), .r(r), .f(f));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.cipher <= 8'h00;
      ctr <= '0;
      l <= '0;
      r <= '0;
      key_q <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          l <= bus.msg[7:4];
          r <= bus.msg[3:0];
          key_q <= bus.key;
          mode_q <= bus.mode;
          ctr <= '0;
          state <= RUN;
          bus.in_ready <= 1'b0;
          bus.busy <= 1'b1;
        end
        RUN: begin
          l <= r;
          r <= l ^ f;
          ctr <= ctr == LAST ? '0 : ctr + 1'b1;
          // final swap undone: cipher = {new R, new L}
          if (ctr == LAST) begin
            state <= DONE;
            bus.out_valid <= 1'b1;
            bus.cipher <= {l ^ f, r};
          end
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdes_round_sequencer.sv
// tb_sdes_round_sequencer: randomized self-checking bench for 1-round and 4-round sequencers
module tb_sdes_round_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cmp = 0;
  int bad = 0;
  int sbox [4][16] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
    '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
    '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
    '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}
  };
  always #5 clk = ~clk;
  sdes_round_sequencer_if bus1();
  sdes_round_sequencer_if bus4();
  sdes_round_sequencer #(.NROUNDS(1), .CTR_W(4)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  sdes_round_sequencer #(.NROUNDS(4), .CTR_W(3)) u4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  function automatic logic [7:0] model(input logic [7:0] m, input logic [11:0] k, input logic md, input int n);
    int lh, rh, kk;
    lh = int'(m) >> 4;
    rh = int'(m) & 15;
    kk = int'(k);
    for (int t = 0; t < n; t++) begin
      int i, rot, rk, e, x, s, fv, nl;
      i = md ? n - 1 - t : t;
      rot = ((kk << i) | (kk >> (12 - i))) & 4095;
      rk = rot >> 6;
      e = (((rh >> 3) & 1) << 5) | (((rh >> 2) & 1) << 4) | (((rh >> 2) & 1) << 3)
        | (((rh >> 1) & 1) << 2) | (((rh >> 1) & 1) << 1) | (rh & 1);
      x = e ^ rk;
      s = sbox[(((x >> 5) & 1) * 2) + (x & 1)][(x >> 1) & 15];
      fv = (((s >> 2) & 1) << 3) | (((s >> 1) & 1) << 2) | (((s >> 3) & 1) << 1) | (s & 1);
      nl = rh;
      rh = lh ^ fv;
      lh = nl;
    end
    return 8'((rh << 4) | lh);
  endfunction

  task automatic xfer4(input logic [7:0] m, input logic [11:0] k, input logic md, output logic [7:0] c, output int lat);
    bus4.msg = m; bus4.key = k; bus4.mode = md; bus4.in_valid = 1'b1;
    @(posedge clk); #1 bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    c = bus4.cipher;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1 bus4.out_ready = 1'b0;
  endtask

  task automatic xfer1(input logic [7:0] m, input logic [11:0] k, input logic md, output logic [7:0] c, output int lat);
    bus1.msg = m; bus1.key = k; bus1.mode = md; bus1.in_valid = 1'b1;
    @(posedge clk); #1 bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    c = bus1.cipher;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1 bus1.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp++;
    if ({bus4.in_ready, bus4.out_valid, bus4.busy, bus4.cipher} !== {3'b100, 8'h00}) begin
      bad++; $display("FAIL reset4: rdy/vld/busy/cipher=%b%b%b/%h expected 100/00", bus4.in_ready, bus4.out_valid, bus4.busy, bus4.cipher);
    end
    cmp++;
    if ({bus1.in_ready, bus1.out_valid, bus1.busy, bus1.cipher} !== {3'b100, 8'h00}) begin
      bad++; $display("FAIL reset1: rdy/vld/busy/cipher=%b%b%b/%h expected 100/00", bus1.in_ready, bus1.out_valid, bus1.busy, bus1.cipher);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_round;
    logic [7:0] c, m;
    logic [11:0] k;
    logic md;
    int lat;
    xfer1(8'h8D, 12'hA80, 1'b0, c, lat);
    cmp++;
    if (c !== 8'h4D || lat !== 1) begin
      bad++; $display("FAIL n1_encrypt: cipher=%h lat=%0d expected 4d lat=1", c, lat);
    end
    xfer1(8'h4D, 12'hA80, 1'b1, c, lat);
    cmp++;
    if (c !== 8'h8D || lat !== 1) begin
      bad++; $display("FAIL n1_decrypt: cipher=%h lat=%0d expected 8d lat=1", c, lat);
    end
    for (int n = 0; n < 20; n++) begin
      m = 8'($urandom); k = 12'($urandom); md = 1'($urandom);
      xfer1(m, k, md, c, lat);
      cmp++;
      if (c !== model(m, k, md, 1) || lat !== 1) begin
        bad++; $display("FAIL n1_random: msg=%h key=%h mode=%b cipher=%h lat=%0d expected %h lat=1", m, k, md, c, lat, model(m, k, md, 1));
      end
    end
  endtask

  task automatic test_roundtrip;
    logic [7:0] m, c, d;
    logic [11:0] k;
    int lat, lat2;
    for (int n = 0; n < 1000; n++) begin
      m = 8'($urandom); k = 12'($urandom);
      xfer4(m, k, 1'b0, c, lat);
      cmp++;
      if (c !== model(m, k, 1'b0, 4) || lat !== 4) begin
        bad++; $display("FAIL roundtrip_enc: msg=%h key=%h cipher=%h lat=%0d expected %h lat=4", m, k, c, lat, model(m, k, 1'b0, 4));
      end
      xfer4(c, k, 1'b1, d, lat2);
      cmp++;
      if (d !== m || lat2 !== 4) begin
        bad++; $display("FAIL roundtrip_dec: key=%h plain=%h lat=%0d expected %h lat=4", k, d, lat2, m);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] m, m2, c0;
    logic [11:0] k, k2;
    int lat;
    m = 8'($urandom); k = 12'($urandom); m2 = 8'($urandom); k2 = 12'($urandom);
    bus4.msg = m; bus4.key = k; bus4.mode = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk); #1 bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    c0 = bus4.cipher;
    cmp++;
    if (c0 !== model(m, k, 1'b0, 4) || lat !== 4) begin
      bad++; $display("FAIL bp_first: cipher=%h lat=%0d expected %h lat=4", c0, lat, model(m, k, 1'b0, 4));
    end
    bus4.msg = m2; bus4.key = k2; bus4.in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      cmp++;
      if (bus4.cipher !== c0 || bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold: cycle=%0d cipher=%h rdy=%b vld=%b expected %h rdy=0 vld=1", t, bus4.cipher, bus4.in_ready, bus4.out_valid, c0);
      end
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1 bus4.out_ready = 1'b0;
    cmp++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) begin
      bad++; $display("FAIL bp_release: rdy=%b vld=%b busy=%b expected 1 0 0", bus4.in_ready, bus4.out_valid, bus4.busy);
    end
    @(posedge clk); #1 bus4.in_valid = 1'b0;
    cmp++;
    if (bus4.in_ready !== 1'b0 || bus4.busy !== 1'b1) begin
      bad++; $display("FAIL bp_accept: rdy=%b busy=%b expected 0 1", bus4.in_ready, bus4.busy);
    end
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    cmp++;
    if (bus4.cipher !== model(m2, k2, 1'b0, 4) || lat !== 4) begin
      bad++; $display("FAIL bp_second: cipher=%h lat=%0d expected %h lat=4", bus4.cipher, lat, model(m2, k2, 1'b0, 4));
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1 bus4.out_ready = 1'b0;
  endtask

  task automatic test_input_change;
    logic [7:0] m;
    logic [11:0] k;
    logic md;
    int lat;
    for (int n = 0; n < 20; n++) begin
      m = 8'($urandom); k = 12'($urandom); md = 1'($urandom);
      bus4.msg = m; bus4.key = k; bus4.mode = md; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      for (int t = 0; t < 3; t++) begin
        bus4.msg = 8'($urandom); bus4.key = 12'($urandom); bus4.mode = 1'($urandom);
        bus4.in_valid = 1'($urandom); bus4.out_ready = 1'($urandom);
        @(posedge clk); #1;
        cmp++;
        if (bus4.out_valid !== 1'b0) begin
          bad++; $display("FAIL chg_early_valid: cycle=%0d out_valid=%b expected 0", t, bus4.out_valid);
        end
      end
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
      lat = 0;
      while (!bus4.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      cmp++;
      if (bus4.cipher !== model(m, k, md, 4) || lat !== 1) begin
        bad++; $display("FAIL chg_result: msg=%h key=%h mode=%b cipher=%h lat=%0d expected %h lat=1", m, k, md, bus4.cipher, lat, model(m, k, md, 4));
      end
      bus4.out_ready = 1'b1;
      @(posedge clk); #1 bus4.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] m, c;
    logic [11:0] k;
    int lat, stale;
    xfer4(8'h5A, 12'h3C7, 1'b0, c, lat);
    m = 8'($urandom); k = 12'($urandom);
    bus4.msg = m; bus4.key = k; bus4.mode = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk); #1 bus4.in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    cmp++;
    if ({bus4.in_ready, bus4.out_valid, bus4.busy, bus4.cipher} !== {3'b100, 8'h00}) begin
      bad++; $display("FAIL rst_mid_run: rdy/vld/busy/cipher=%b%b%b/%h expected 100/00", bus4.in_ready, bus4.out_valid, bus4.busy, bus4.cipher);
    end
    stale = 0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (bus4.out_valid !== 1'b0) stale++;
    end
    cmp++;
    if (stale !== 0) begin
      bad++; $display("FAIL rst_stale_valid: cycles with out_valid=%0d expected 0", stale);
    end
    xfer4(m, k, 1'b0, c, lat);
    cmp++;
    if (c !== model(m, k, 1'b0, 4) || lat !== 4) begin
      bad++; $display("FAIL rst_fresh: cipher=%h lat=%0d expected %h lat=4", c, lat, model(m, k, 1'b0, 4));
    end
  endtask

  initial begin
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.mode = 1'b0; bus1.msg = 8'h00; bus1.key = 12'h000;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.mode = 1'b0; bus4.msg = 8'h00; bus4.key = 12'h000;
    test_reset;
    test_single_round;
    test_roundtrip;
    test_backpressure;
    test_input_change;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
